// File: rtl/dotprod_sched_pkg.sv
// Shared types and defaults for the dot-product kernel scheduler.
// Job records are queued whole and replayed to the kernel as k_n/k_a_base/k_b_base.
package dotprod_sched_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DONE_W          = 16;
  localparam int unsigned DEF_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 65535;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] a_base;
    logic [DATA_W-1:0] b_base;
  } job_t;

endpackage

// File: rtl/dotprod_job_fifo.sv
// Job queue: power-of-two FIFO of job records with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dotprod_job_fifo
  import dotprod_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic push,
  input  logic pop,
  input  job_t din,
  output job_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  job_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    dout  = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/dotprod_sched.sv
// Scheduler that feeds queued dot-product jobs one at a time to an HLS-style
// kernel (ap_start handshake), with a WAIT timeout and a result handshake.
module dotprod_sched
  import dotprod_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [DATA_W-1:0] job_n,
  input  logic [DATA_W-1:0] job_a_base,
  input  logic [DATA_W-1:0] job_b_base,
  output logic              k_start,
  output logic [DATA_W-1:0] k_n,
  output logic [DATA_W-1:0] k_a_base,
  output logic [DATA_W-1:0] k_b_base,
  input  logic              k_ready,
  input  logic              k_done,
  input  logic [DATA_W-1:0] k_return,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic [DONE_W-1:0] jobs_done
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      state_next;
  job_t        q_din;
  job_t        q_head;
  logic        q_full;
  logic        q_empty;
  logic        q_push;
  logic        q_pop;
  logic        ld_op;
  logic        cap_ret;
  logic        cap_zero;
  logic        cap_tmo;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        done_inc;
  logic [31:0] tmo_cnt;

  assign q_din  = '{n: job_n, a_base: job_a_base, b_base: job_b_base};
  assign q_push = job_valid && !q_full;

  dotprod_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .push   (q_push),
    .pop    (q_pop),
    .din    (q_din),
    .dout   (q_head),
    .full   (q_full),
    .empty  (q_empty)
  );

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) state <= S_IDLE;
    else         state <= state_next;
  end

  // Timeout fires on the TIMEOUT_CYC-th WAIT cycle; k_done is tested first so it wins.
  always_comb begin
    state_next = state;
    q_pop      = 1'b0;
    ld_op      = 1'b0;
    cap_ret    = 1'b0;
    cap_zero   = 1'b0;
    cap_tmo    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    done_inc   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop = 1'b1;
          ld_op = 1'b1;
          if (q_head.n != '0) begin
            state_next = S_LAUNCH;
          end else begin
            cap_zero   = 1'b1;
            state_next = S_RESULT;
          end
        end
      end
      S_LAUNCH: begin
        if (k_ready) begin
          if (k_done) begin
            cap_ret    = 1'b1;
            state_next = S_RESULT;
          end else begin
            cnt_clr    = 1'b1;
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (k_done) begin
          cap_ret    = 1'b1;
          state_next = S_RESULT;
        end else if (tmo_cnt >= TMO_LAST) begin
          cap_tmo    = 1'b1;
          state_next = S_RESULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          done_inc   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    k_start   = (state == S_LAUNCH);
    res_valid = (state == S_RESULT);
    busy      = (state != S_IDLE) || !q_empty;
    job_ready = !q_full;
  end

  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      k_n       <= '0;
      k_a_base  <= '0;
      k_b_base  <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      tmo_cnt   <= '0;
      jobs_done <= '0;
    end else begin
      if (ld_op) begin
        k_n      <= q_head.n;
        k_a_base <= q_head.a_base;
        k_b_base <= q_head.b_base;
      end
      if (cap_ret) begin
        res_data <= k_return;
        res_err  <= 1'b0;
      end else if (cap_zero) begin
        res_data <= '0;
        res_err  <= 1'b0;
      end else if (cap_tmo) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + 32'd1;
      if (done_inc) jobs_done <= jobs_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_dotprod_sched.sv
// Randomized scoreboard bench for dotprod_sched with a behavioural kernel model.
module tb_dotprod_sched;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;
  localparam int unsigned NEVER = 1000;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_n = '0, job_a_base = '0, job_b_base = '0;
  logic        k_start;
  logic [31:0] k_n, k_a_base, k_b_base;
  logic        k_ready = 1'b0, k_done = 1'b0;
  logic [31:0] k_return = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;
  logic [15:0] jobs_done;

  always #5 ap_clk = ~ap_clk;

  dotprod_sched #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_n      (job_n),
    .job_a_base (job_a_base),
    .job_b_base (job_b_base),
    .k_start    (k_start),
    .k_n        (k_n),
    .k_a_base   (k_a_base),
    .k_b_base   (k_b_base),
    .k_ready    (k_ready),
    .k_done     (k_done),
    .k_return   (k_return),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  // r: cycles before k_ready; d: cycles from k_ready to k_done (0 = same cycle)
  typedef struct {
    int unsigned r;
    int unsigned d;
    bit          fixed;
    logic [31:0] ret;
  } plan_t;

  exp_t        exp_q[$];
  plan_t       plan_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  bit          hold_rr    = 1'b0;
  logic [15:0] done_cnt   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] kfun(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b);
    return (n * 32'd3) ^ {a[30:0], 1'b0} ^ {b[28:0], 3'b000} ^ 32'h5A5A_0000;
  endfunction

  // A job completes iff k_done lands within the first TMO WAIT cycles.
  function automatic exp_t ref_result(input logic [31:0] n, input logic [31:0] a,
                                      input logic [31:0] b, input plan_t p);
    exp_t e;
    if (n == 0)          e = '{32'd0, 1'b0};
    else if (p.d > TMO)  e = '{32'd0, 1'b1};
    else if (p.fixed)    e = '{p.ret, 1'b0};
    else                 e = '{kfun(n, a, b), 1'b0};
    return e;
  endfunction

  function automatic plan_t mkplan(input int unsigned r, input int unsigned d);
    plan_t p;
    p = '{r, d, 1'b0, 32'd0};
    return p;
  endfunction

  task automatic accept(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b, input plan_t p);
    exp_q.push_back(ref_result(n, a, b, p));
    if (n != 0) plan_q.push_back(p);
  endtask

  task automatic submit(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b, input plan_t p);
    int unsigned waitc = 0;
    @(negedge ap_clk);
    job_valid = 1'b1; job_n = n; job_a_base = a; job_b_base = b;
    while (!job_ready && waitc < 300) begin
      @(negedge ap_clk);
      waitc++;
    end
    if (job_ready) accept(n, a, b, p);
    else           check("job_ready_wait", 32'd0, 32'd1);
    @(posedge ap_clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned c = 0;
    while ((exp_q.size() != 0 || busy) && c < 3000) begin
      @(negedge ap_clk);
      c++;
    end
    check("drain_in_time", (exp_q.size() == 0 && !busy), 32'd1);
    @(negedge ap_clk);
  endtask

  initial begin
    forever begin
      @(negedge ap_clk);
      res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    plan_t p;
    forever begin
      @(negedge ap_clk);
      if (ap_rst && k_start) begin
        check("k_start_has_job", plan_q.size() != 0, 32'd1);
        if (plan_q.size() != 0) p = plan_q.pop_front();
        else                    p = mkplan(0, NEVER);
        repeat (p.r) @(negedge ap_clk);
        k_ready = 1'b1;
        if (p.d == 0) begin
          k_done   = 1'b1;
          k_return = p.fixed ? p.ret : kfun(k_n, k_a_base, k_b_base);
        end
        @(negedge ap_clk);
        k_ready = 1'b0;
        k_done  = 1'b0;
        if (p.d > 0 && p.d < NEVER) begin
          repeat (p.d - 1) @(negedge ap_clk);
          k_done   = 1'b1;
          k_return = p.fixed ? p.ret : kfun(k_n, k_a_base, k_b_base);
          @(negedge ap_clk);
          k_done = 1'b0;
        end
      end
    end
  end

  initial begin
    bit          hold_v = 1'b0;
    logic [31:0] hold_d = '0;
    logic        hold_e = 1'b0;
    exp_t        e;
    forever begin
      @(negedge ap_clk);
      #1;
      if (!ap_rst) begin
        hold_v   = 1'b0;
        done_cnt = '0;
        continue;
      end
      if (hold_v) begin
        check("res_valid_held", res_valid, 32'd1);
        check("res_data_held", res_data, hold_d);
        check("res_err_held", res_err, hold_e);
      end
      hold_v = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          check("result_expected", exp_q.size() != 0, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_err", res_err, e.err);
          end
          check("jobs_done_before_ack", jobs_done, done_cnt);
          done_cnt = done_cnt + 16'd1;
        end else begin
          hold_v = 1'b1;
          hold_d = res_data;
          hold_e = res_err;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    plan_t       p;
    int unsigned acc;
    int unsigned cyc;
    int unsigned bad;
    logic [15:0] snap;
    logic [31:0] n, a, b;

    // Reset values while held in reset
    #2;
    check("rst_k_start", k_start, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_err", res_err, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_k_n", k_n, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 check("job_ready_after_rst", job_ready, 1);

    // Single reference job: ready after 2 cycles, done 8 later, fixed 0x2A
    p = '{2, 8, 1'b1, 32'h0000_002A};
    submit(32'd4, 32'h100, 32'h200, p);
    wait_drain();
    check("jobs_done_one", jobs_done, 1);

    // n = 0: no kernel start, result within 2 cycles
    submit(32'd0, 32'h1234, 32'h5678, mkplan(0, 0));
    cyc = 0; bad = 0;
    while (!res_valid && cyc < 10) begin
      @(posedge ap_clk);
      #1;
      cyc++;
      if (k_start) bad++;
    end
    check("n0_latency_le2", cyc <= 2, 1);
    check("n0_no_k_start", bad, 0);
    wait_drain();

    // Timeout boundaries: d=16 completes, d=17 and never abort; next job normal
    submit(32'd7, 32'hA0, 32'hB0, mkplan(1, 16));
    submit(32'd8, 32'hA1, 32'hB1, mkplan(0, 17));
    submit(32'd9, 32'hA2, 32'hB2, mkplan(0, NEVER));
    submit(32'd10, 32'hA3, 32'hB3, mkplan(2, 3));
    submit(32'd11, 32'hA4, 32'hB4, mkplan(0, 0));
    wait_drain();

    // Kernel stalled in LAUNCH: one job popped, DEPTH more fill the queue
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ap_clk);
      job_valid = 1'b1; job_n = 32'(i + 1); job_a_base = 32'(i * 16); job_b_base = 32'(i * 32);
      if (!job_ready) break;
      accept(job_n, job_a_base, job_b_base, mkplan((i == 0) ? 12 : 1, 2));
      acc++;
    end
    @(posedge ap_clk);
    #1;
    job_valid = 1'b0;
    check("stall_accepted", acc, DEPTH + 1);
    check("stall_job_ready_low", job_ready, 0);
    wait_drain();

    // Result back-pressure: no further launch, no count until ack
    hold_rr = 1'b1;
    submit(32'd21, 32'hC0, 32'hD0, mkplan(0, 2));
    submit(32'd22, 32'hC1, 32'hD1, mkplan(0, 2));
    cyc = 0;
    while (!res_valid && cyc < 100) begin
      @(negedge ap_clk);
      cyc++;
    end
    check("bp_res_valid_seen", res_valid, 1);
    snap = jobs_done;
    bad = 0;
    repeat (20) begin
      @(negedge ap_clk);
      #2;
      if (k_start || !res_valid) bad++;
    end
    check("bp_stall_clean", bad, 0);
    check("bp_jobs_done_frozen", jobs_done, snap);
    hold_rr = 1'b0;
    wait_drain();
    check("bp_jobs_done_after", jobs_done, snap + 16'd2);

    // Reset during WAIT with two queued jobs
    submit(32'd31, 32'hE0, 32'hF0, mkplan(0, NEVER));
    submit(32'd32, 32'hE1, 32'hF1, mkplan(0, 2));
    submit(32'd33, 32'hE2, 32'hF2, mkplan(0, 2));
    repeat (4) @(negedge ap_clk);
    #2 ap_rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    #1;
    check("wrst_k_start", k_start, 0);
    check("wrst_res_valid", res_valid, 0);
    check("wrst_res_data", res_data, 0);
    check("wrst_res_err", res_err, 0);
    check("wrst_jobs_done", jobs_done, 0);
    check("wrst_k_n", k_n, 0);
    check("wrst_k_a_base", k_a_base, 0);
    check("wrst_k_b_base", k_b_base, 0);
    check("wrst_busy", busy, 0);
    repeat (2) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 check("wrst_job_ready", job_ready, 1);
    bad = 0;
    repeat (30) begin
      @(negedge ap_clk);
      #2;
      if (res_valid || k_start || busy) bad++;
    end
    check("wrst_no_stale", bad, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int unsigned k;
      n = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 9);
      if (k == 0)      p = mkplan($urandom_range(0, 3), NEVER);
      else if (k == 1) p = mkplan($urandom_range(0, 3), 16);
      else if (k == 2) p = mkplan($urandom_range(0, 3), 17);
      else             p = mkplan($urandom_range(0, 3), $urandom_range(0, 15));
      submit(n, a, b, p);
      repeat ($urandom_range(0, 2)) @(negedge ap_clk);
    end
    wait_drain();
    check("final_jobs_done", jobs_done, done_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
